// File: rtl/axis_pkg.sv
// Shared types for the AXI-Stream slave: beat payload width and the stored beat record.
package axis_pkg;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } axis_beat_t;
endpackage

// File: rtl/axis_s_fifo.sv
// First-word-fall-through beat buffer; head reads storage directly and shows 0 when empty.
module axis_s_fifo
  import axis_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       push,
  input  logic       pop,
  input  axis_beat_t din,
  output logic       full,
  output logic       empty,
  output axis_beat_t head
);
  localparam int AW = $clog2(DEPTH);

  axis_beat_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt;
  logic            do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign head    = empty ? '0 : mem[rd_ptr];

  // DEPTH is a power of 2, so pointer overflow is the modulo wrap
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge aclk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/axis_s.sv
// AXI-Stream slave: buffers beats, exposes a pop port, reports per-packet beat count.
// Optional AXIS_S_LEN_CHECK_EN: saturating count at MAX_PKT with sticky len_err.
module axis_s
  import axis_pkg::*;
#(
  parameter int DATA_W  = axis_pkg::DATA_W,
  parameter int DEPTH   = 8,
  parameter int MAX_PKT = 16,
  localparam int LEN_W  = $clog2(MAX_PKT + 1)
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              tvalid,
  output logic              tready,
  input  logic [DATA_W-1:0] tdata,
  input  logic              tlast,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_en,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic              len_err
);
  logic             full, empty, acc;
  axis_beat_t       din, head;
  logic [LEN_W-1:0] beat_cnt;

  assign tready   = !full && !areset;
  assign acc      = tvalid && tready;
  assign din      = '{last: tlast, data: tdata};
  assign rd_valid = !empty;
  assign rd_data  = head.data;
  assign rd_last  = head.last;

  axis_s_fifo #(.DEPTH(DEPTH)) u_fifo (
    .aclk  (aclk),
    .areset(areset),
    .push  (acc),
    .pop   (rd_en),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef AXIS_S_LEN_CHECK_EN
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_PKT);
  logic at_max;
  assign at_max = beat_cnt == MAX_L;

  // count pins at MAX_PKT; any beat arriving while pinned is an over-length packet
  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt <= '0;
      pkt_len  <= '0;
      pkt_done <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      pkt_done <= acc && tlast;
      if (acc) begin
        if (at_max) len_err <= 1'b1;
        if (tlast) begin
          pkt_len  <= at_max ? MAX_L : beat_cnt + 1'b1;
          beat_cnt <= '0;
        end else if (!at_max) begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign len_err = 1'b0;

  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt <= '0;
      pkt_len  <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= acc && tlast;
      if (acc) begin
        if (tlast) begin
          pkt_len  <= beat_cnt + 1'b1;
          beat_cnt <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end
`endif
endmodule

// File: tb/tb_axis_s.sv
// Bench for axis_s: directed scenarios plus random traffic against a queue-based reference model.
module tb_axis_s;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 8;
  localparam int MAX_PKT = 16;
  localparam int LEN_W   = $clog2(MAX_PKT + 1);

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic              tvalid = 1'b0, tlast = 1'b0, rd_en = 1'b0;
  logic [DATA_W-1:0] tdata = '0;
  logic              tready, rd_valid, rd_last, pkt_done, len_err;
  logic [DATA_W-1:0] rd_data;
  logic [LEN_W-1:0]  pkt_len;

  axis_s #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_PKT(MAX_PKT)) dut (
    .aclk(aclk), .areset(areset), .tvalid(tvalid), .tready(tready),
    .tdata(tdata), .tlast(tlast), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .rd_en(rd_en), .pkt_done(pkt_done), .pkt_len(pkt_len),
    .len_err(len_err)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0, n_fail = 0;

  // reference model: beat queue, beats-in-packet as a plain integer
  logic [DATA_W:0] q[$];
  int  cur_cnt = 0;
  int  exp_len = 0;
  bit  exp_done = 0, exp_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [DATA_W:0] hd;
    hd = (q.size() > 0) ? q[0] : '0;
    chk("tready",   64'(tready),   64'(!areset && q.size() < DEPTH));
    chk("rd_valid", 64'(rd_valid), 64'(q.size() > 0));
    chk("rd_data",  64'(rd_data),  64'(hd[DATA_W-1:0]));
    chk("rd_last",  64'(rd_last),  64'(hd[DATA_W]));
    chk("pkt_done", 64'(pkt_done), 64'(exp_done));
    chk("pkt_len",  64'(pkt_len),  64'(exp_len));
    chk("len_err",  64'(len_err),  64'(exp_err));
  endtask

  // check state seen so far, drive the next cycle's inputs, advance the model across that edge
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic l,
                      input logic r, input logic rst);
    bit acc, popv;
    @(negedge aclk);
    check_outputs();
    tvalid = v; tdata = d; tlast = l; rd_en = r; areset = rst;
    if (rst) begin
      q.delete();
      cur_cnt = 0; exp_len = 0; exp_done = 0; exp_err = 0;
    end else begin
      acc  = v && (q.size() < DEPTH);
      popv = r && (q.size() > 0);
      exp_done = acc && l;
      if (popv) void'(q.pop_front());
      if (acc) begin
        q.push_back({l, d});
`ifdef AXIS_S_LEN_CHECK_EN
        if (cur_cnt >= MAX_PKT) exp_err = 1;
`endif
        cur_cnt++;
        if (l) begin
`ifdef AXIS_S_LEN_CHECK_EN
          exp_len = (cur_cnt > MAX_PKT) ? MAX_PKT : cur_cnt;
`else
          exp_len = cur_cnt % (1 << LEN_W);
`endif
          cur_cnt = 0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset held 4 cycles, then idle: tready rises the first cycle out of reset
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // single-beat packet
    step(1'b1, 32'haaaa_bbbb, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(1);

    // fill to full, hold a refused beat, pop once to let it in, then drain
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'hcccc_dddd, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hcccc_dddd, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'hcccc_dddd, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'hcccc_dddd, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // streaming 5-beat packet with continuous pop
    for (int i = 0; i < 5; i++) step(1'b1, 32'h5000_0000 + 32'(i), i == 4, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(1);

    // reset mid-packet, then a 2-beat packet
    for (int i = 0; i < 3; i++) step(1'b1, 32'h3000_0000 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b1, 32'h2000_0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h2000_0002, 1'b1, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // over-length packet (18 beats)
    for (int i = 0; i < 18; i++) step(1'b1, 32'h1800_0000 + 32'(i), i == 17, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);

    // random traffic; alternating pop pressure so the buffer both fills and drains
    for (int i = 0; i < 2000; i++) begin
      logic r;
      r = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 5) == 0, r,
           $urandom_range(0, 299) == 0);
    end
    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge aclk);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_s.md
# axis_s

AXI-Stream slave (receiver) that terminates the stream produced by `axis_m`. Accepts 32-bit beats with `tlast` framing into a small first-word-fall-through buffer, presents them to downstream logic through a pop interface, and reports per-packet beat count with a one-cycle completion pulse. Sits between an AXI-Stream master and a local consumer in the same `aclk` domain.

## Interface
- `DATA_W`, 32, width of `tdata` and `rd_data`
- `DEPTH`, 8, buffer entries; power of 2, ≥2
- `MAX_PKT`, 16, maximum legal beats per packet
- `LEN_W`, `$clog2(MAX_PKT+1)`, width of `pkt_len` (derived, not overridden)

Ports:
- `aclk`  in  1  clock; one clock, all logic on rising edge
- `areset`  in  1  reset; synchronous, active-high
- `tvalid`  in  1  master has a beat
- `tready`  out  1  slave can accept a beat
- `tdata`  in  DATA_W  beat payload
- `tlast`  in  1  last beat of packet
- `rd_valid`  out  1  buffer head valid (not empty)
- `rd_data`  out  DATA_W  head payload
- `rd_last`  out  1  head `tlast`
- `rd_en`  in  1  pop head; ignored when `rd_valid`=0
- `pkt_done`  out  1  one-cycle pulse: `tlast` beat accepted
- `pkt_len`  out  LEN_W  beat count of last completed packet
- `len_err`  out  1  sticky over-length flag

## Operation
- Accept: beat is taken on an edge where `tvalid && tready`; `{tlast, tdata}` is written to the tail.
- `tready = !full && !areset`, from registered occupancy. Never depends on `tvalid`.
- Pop: on `rd_en && rd_valid` the head advances. `rd_data`/`rd_last` show the head combinationally from storage; X-free (0) when empty.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. At full `tready`=0, so no push occurs; a pop at full raises `tready` the next cycle.
- Pointers wrap modulo `DEPTH`; occupancy counter is `$clog2(DEPTH)+1` bits.
- Packet counter `beat_cnt`: +1 per accepted beat. On an accepted `tlast` beat: `pkt_len <= beat_cnt+1`, `pkt_done <= 1`, `beat_cnt <= 0`. `pkt_len` holds until the next completion.
- Single-beat packet (`tlast` on first beat): `pkt_len`=1.
- Master dropping `tvalid` mid-packet: no effect on counters.

## Timing
- Reset values: `tready`=0, `rd_valid`=0, `rd_data`=0, `rd_last`=0, `pkt_done`=0, `pkt_len`=0, `len_err`=0; buffer empty, `beat_cnt`=0.
- First cycle after `areset` falls: `tready`=1.
- Latency: beat accepted at edge N → `rd_valid`=1 with that beat from edge N (visible cycle N+1) when buffer was empty.
- `pkt_done` asserts the cycle after the accepting edge, for exactly one cycle; back-to-back single-beat packets give consecutive pulses.
- Reset mid-packet or with data buffered: buffer flushed, partial count discarded, no `pkt_done` emitted.

## Configuration
- `AXIS_S_LEN_CHECK_EN` defined: `beat_cnt` saturates at `MAX_PKT`; accepting a beat while `beat_cnt`=`MAX_PKT` sets `len_err` (sticky until `areset`); completion reports `pkt_len`=`MAX_PKT`. Data still buffered normally.
- Not defined: `len_err` tied 0; `beat_cnt` wraps modulo 2^LEN_W; no saturation logic.

## Structure
- Package `axis_pkg`: `DATA_W` default constant, `typedef struct packed {logic last; logic [DATA_W-1:0] data;} axis_beat_t`.
- Sub-module `axis_s_fifo`: synchronous FWFT FIFO of `axis_beat_t`, ports push/pop/full/empty/head. `axis_s` holds handshake and packet counter logic.

## Test plan
- Reset 4 cycles, `rd_en`=0 → all outputs 0 during reset; `tready`=1 first cycle after.
- One beat `32'haaaa_bbbb`, `tlast`=1 → `rd_valid`=1, `rd_data`=`32'haaaa_bbbb`, `rd_last`=1 next cycle; `pkt_done` one-cycle pulse, `pkt_len`=1.
- 8 beats with `rd_en`=0, `DEPTH`=8 → `tready`=0 after 8th; hold `tvalid` with `32'hcccc_dddd`; single pop → `tready`=1 next cycle, beat accepted, order preserved.
- Continuous `tvalid` and `rd_en` for 5-beat packet → 1 beat/cycle throughput, `pkt_len`=5, occupancy never exceeds 1.
- Assert `areset` after 3 of 5 beats, then send 2-beat packet → buffer empty after reset, no `pkt_done` for partial, then `pkt_len`=2.
- With `AXIS_S_LEN_CHECK_EN`, 18-beat packet, `MAX_PKT`=16 → `len_err`=1 after 17th beat and stays set, `pkt_len`=16; without macro `len_err`=0.
